text_term: RTL and testbench



---
 rtl/text_term_if.sv | 30 +++
 rtl/text_term.sv | 166 ++++++++++++++++
 tb/tb_text_term.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/text_term_if.sv
// Stream/tram bundle between a character source, text_term and the tram write port.
interface text_term_if #(
  parameter int WORD  = 32,
  parameter int ADDRW = 14,
  parameter int CIDXW = 4
);
  logic             clear;
  logic [CIDXW-1:0] colr_fg;
  logic [CIDXW-1:0] colr_bg;
  logic             ch_valid;
  logic [20:0]      ch_data;
  logic             ch_ready;
  logic             tram_we;
  logic [ADDRW-1:0] tram_addr;
  logic [WORD-1:0]  tram_wdata;
  logic [ADDRW-1:0] scroll_offs;
  logic [ADDRW-1:0] cur_x;
  logic [ADDRW-1:0] cur_y;
  logic             busy;

  modport master (
    output clear, colr_fg, colr_bg, ch_valid, ch_data,
    input  ch_ready, tram_we, tram_addr, tram_wdata, scroll_offs, cur_x, cur_y, busy
  );

  modport slave (
    input  clear, colr_fg, colr_bg, ch_valid, ch_data,
    output ch_ready, tram_we, tram_addr, tram_wdata, scroll_offs, cur_x, cur_y, busy
  );
endinterface

// File: rtl/text_term.sv
// Terminal writer: turns a code-point stream into tram writes with cursor, wrap, ring scroll and clear.
// Printable chars write one cycle after handshake; a scroll stalls input for TRAM_HRES cycles.
module text_term #(
  parameter int WORD      = 32,
  parameter int ADDRW     = 14,
  parameter int CIDXW     = 4,
  parameter int TRAM_HRES = 84,
  parameter int TRAM_VRES = 24
) (
  input  logic        clk,
  input  logic        rst,
  text_term_if.slave  bus
);
  localparam logic [ADDRW-1:0] HRES      = ADDRW'(TRAM_HRES);
  localparam logic [ADDRW-1:0] XMAX      = ADDRW'(TRAM_HRES - 1);
  localparam logic [ADDRW-1:0] YMAX      = ADDRW'(TRAM_VRES - 1);
  localparam logic [ADDRW-1:0] LAST_ROW  = ADDRW'((TRAM_VRES - 1) * TRAM_HRES);
  localparam logic [ADDRW-1:0] LAST_CELL = ADDRW'(TRAM_HRES * TRAM_VRES - 1);

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_LINE} state_t;

  state_t           state_q, state_d;
  logic [ADDRW-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic [ADDRW-1:0] row_base_q, row_base_d, scroll_q, scroll_d;
  logic [ADDRW-1:0] cnt_q, cnt_d, addr_q, addr_d;
  logic [WORD-1:0]  wdata_q, wdata_d;
  logic [CIDXW-1:0] fg_q, fg_d, bg_q, bg_d;
  logic             we_q, we_d, pend_q, pend_d;
  logic             hs, newline;

  function automatic logic [WORD-1:0] make_word(input logic [CIDXW-1:0] bg,
                                                input logic [CIDXW-1:0] fg,
                                                input logic [20:0]      ucp);
    logic [WORD-1:0] w;
    w = '0;
    w[WORD-1 -: CIDXW]       = bg;
    w[WORD-CIDXW-1 -: CIDXW] = fg;
    w[20:0]                  = ucp;
    return w;
  endfunction

  // Ring step: the last physical row wraps back to address 0.
  function automatic logic [ADDRW-1:0] next_row(input logic [ADDRW-1:0] a);
    return (a == LAST_ROW) ? '0 : a + HRES;
  endfunction

  assign bus.ch_ready    = (state_q == IDLE) && !pend_q && !bus.clear && !rst;
  assign hs              = bus.ch_valid && bus.ch_ready;
  assign bus.tram_we     = we_q;
  assign bus.tram_addr   = addr_q;
  assign bus.tram_wdata  = wdata_q;
  assign bus.scroll_offs = scroll_q;
  assign bus.cur_x       = cur_x_q;
  assign bus.cur_y       = cur_y_q;
  assign bus.busy        = (state_q == CLR_ALL);

  always_comb begin
    state_d    = state_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    row_base_d = row_base_q;
    scroll_d   = scroll_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    we_d       = 1'b0;
    pend_d     = pend_q | bus.clear;
    newline    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear || pend_q) begin
          state_d = CLR_ALL;
          cnt_d   = '0;
          fg_d    = bus.colr_fg;
          bg_d    = bus.colr_bg;
        end else if (hs) begin
          if (bus.ch_data >= 21'h20 && bus.ch_data != 21'h7F) begin
            we_d    = 1'b1;
            addr_d  = row_base_q + cur_x_q;
            wdata_d = make_word(bus.colr_bg, bus.colr_fg, bus.ch_data);
            if (cur_x_q == XMAX) begin
              cur_x_d = '0;
              newline = 1'b1;
            end else begin
              cur_x_d = cur_x_q + ADDRW'(1);
            end
          end else if (bus.ch_data == 21'h0A) begin
            cur_x_d = '0;
            newline = 1'b1;
          end else if (bus.ch_data == 21'h0D) begin
            cur_x_d = '0;
          end else if (bus.ch_data == 21'h08 && cur_x_q != '0) begin
            cur_x_d = cur_x_q - ADDRW'(1);
          end
          if (newline) begin
            row_base_d = next_row(row_base_q);
            if (cur_y_q != YMAX) begin
              cur_y_d = cur_y_q + ADDRW'(1);
            end else begin
              // Bottom row: scroll the window and blank the recycled row.
              scroll_d = next_row(scroll_q);
              state_d  = CLR_LINE;
              cnt_d    = '0;
              fg_d     = bus.colr_fg;
              bg_d     = bus.colr_bg;
            end
          end
        end
      end
      CLR_ALL: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = make_word(bg_q, fg_q, 21'h20);
        cnt_d   = cnt_q + ADDRW'(1);
        if (cnt_q == LAST_CELL) begin
          state_d    = IDLE;
          scroll_d   = '0;
          row_base_d = '0;
          cur_x_d    = '0;
          cur_y_d    = '0;
          pend_d     = 1'b0;
        end
      end
      CLR_LINE: begin
        we_d    = 1'b1;
        addr_d  = row_base_q + cnt_q;
        wdata_d = make_word(bg_q, fg_q, 21'h20);
        cnt_d   = cnt_q + ADDRW'(1);
        if (cnt_q == XMAX) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      row_base_q <= '0;
      scroll_q   <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fg_q       <= '0;
      bg_q       <= '0;
      we_q       <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      row_base_q <= row_base_d;
      scroll_q   <= scroll_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      we_q       <= we_d;
      pend_q     <= pend_d;
    end
  end
endmodule

// File: tb/tb_text_term.sv
// Directed bench for text_term on a 4x3 tram with a small tram shadow for clear checks.
module tb_text_term;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   wr_cnt = 0;
  int   w0;
  int   bcnt;
  logic [31:0] mem [16];

  text_term_if #(.WORD(32), .ADDRW(14), .CIDXW(4)) bus ();

  text_term #(.WORD(32), .ADDRW(14), .CIDXW(4), .TRAM_HRES(4), .TRAM_VRES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.tram_we) begin
      mem[bus.tram_addr[3:0]] = bus.tram_wdata;
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ch_valid = 1'b0;
    bus.clear = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send(input logic [20:0] c);
    bus.ch_valid = 1'b1;
    bus.ch_data  = c;
    #1;
    chk("send_rdy", 32'(bus.ch_ready), 32'd1);
    step();
    bus.ch_valid = 1'b0;
  endtask

  task automatic wait_ready(input int bound);
    int n;
    n = 0;
    while (!bus.ch_ready && n < bound) begin
      step();
      n++;
    end
    chk("wait_rdy", 32'(bus.ch_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.clear = 1'b0;
    bus.ch_valid = 1'b0;
    bus.ch_data = '0;
    bus.colr_fg = 4'd2;
    bus.colr_bg = 4'd1;
    for (int i = 0; i < 16; i++) mem[i] = '0;

    // Reset values
    step();
    chk("rst_rdy", 32'(bus.ch_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(bus.tram_we), 32'd0);
    chk("rst_addr", 32'(bus.tram_addr), 32'd0);
    chk("rst_wdata", bus.tram_wdata, 32'd0);
    chk("rst_scroll", 32'(bus.scroll_offs), 32'd0);
    chk("rst_curx", 32'(bus.cur_x), 32'd0);
    chk("rst_cury", 32'(bus.cur_y), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_rdy_out", 32'(bus.ch_ready), 32'd1);

    // Single 'A'
    send(21'h41);
    chk("a_we", 32'(bus.tram_we), 32'd1);
    chk("a_addr", 32'(bus.tram_addr), 32'd0);
    chk("a_wdata", bus.tram_wdata, 32'h12000041);
    chk("a_curx", 32'(bus.cur_x), 32'd1);
    step();
    chk("a_we_off", 32'(bus.tram_we), 32'd0);

    // 'ABCD' back to back, wraps to next row
    do_reset();
    bus.ch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.ch_data = 21'(32'h41 + i);
      step();
      chk("abcd_addr", 32'(bus.tram_addr), 32'(i));
      chk("abcd_wdata", bus.tram_wdata, 32'h12000041 + 32'(i));
    end
    bus.ch_valid = 1'b0;
    chk("abcd_curx", 32'(bus.cur_x), 32'd0);
    chk("abcd_cury", 32'(bus.cur_y), 32'd1);
    chk("abcd_scroll", 32'(bus.scroll_offs), 32'd0);

    // 12 chars fill the screen; the 12th scrolls and blanks physical row 0
    do_reset();
    bus.ch_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus.ch_data = 21'(32'h61 + i);
      step();
      chk("fill_addr", 32'(bus.tram_addr), 32'(i));
    end
    bus.ch_valid = 1'b0;
    chk("fill_wdata", bus.tram_wdata, 32'h1200006C);
    chk("fill_scroll", 32'(bus.scroll_offs), 32'd4);
    chk("fill_cury", 32'(bus.cur_y), 32'd2);
    chk("fill_rdy0", 32'(bus.ch_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("cl_we", 32'(bus.tram_we), 32'd1);
      chk("cl_addr", 32'(bus.tram_addr), 32'(i));
      chk("cl_wdata", bus.tram_wdata, 32'h12000020);
      if (i < 3) chk("cl_rdy", 32'(bus.ch_ready), 32'd0);
    end
    send(21'h5A);
    chk("z_addr", 32'(bus.tram_addr), 32'd0);
    chk("z_wdata", bus.tram_wdata, 32'h1200005A);
    chk("z_cury", 32'(bus.cur_y), 32'd2);
    chk("z_curx", 32'(bus.cur_x), 32'd1);

    // Backspace from (2,1)
    do_reset();
    for (int i = 0; i < 6; i++) send(21'(32'h61 + i));
    step();
    chk("bs_start_x", 32'(bus.cur_x), 32'd2);
    chk("bs_start_y", 32'(bus.cur_y), 32'd1);
    w0 = wr_cnt;
    send(21'h08);
    chk("bs1_x", 32'(bus.cur_x), 32'd1);
    send(21'h08);
    chk("bs2_x", 32'(bus.cur_x), 32'd0);
    send(21'h08);
    chk("bs3_x", 32'(bus.cur_x), 32'd0);
    chk("bs3_y", 32'(bus.cur_y), 32'd1);
    step();
    chk("bs_nowrite", 32'(wr_cnt), 32'(w0));

    // CR, then LFs through two scrolls and the ring wrap 8 -> 0
    do_reset();
    for (int i = 0; i < 3; i++) send(21'(32'h61 + i));
    chk("cr_pre_x", 32'(bus.cur_x), 32'd3);
    step();
    w0 = wr_cnt;
    send(21'h0D);
    chk("cr_x", 32'(bus.cur_x), 32'd0);
    chk("cr_y", 32'(bus.cur_y), 32'd0);
    send(21'h0A);
    send(21'h0A);
    chk("lf2_y", 32'(bus.cur_y), 32'd2);
    step();
    chk("crlf_nowrite", 32'(wr_cnt), 32'(w0));
    send(21'h0A);
    chk("lf_scroll4", 32'(bus.scroll_offs), 32'd4);
    wait_ready(10);
    send(21'h0A);
    chk("lf_scroll8", 32'(bus.scroll_offs), 32'd8);
    wait_ready(10);
    send(21'h0A);
    chk("lf_scroll_wrap", 32'(bus.scroll_offs), 32'd0);
    chk("lf_wrap_y", 32'(bus.cur_y), 32'd2);
    wait_ready(10);

    // Clear beats a simultaneous character; colours latched on entry
    do_reset();
    for (int i = 0; i < 5; i++) send(21'(32'h61 + i));
    step();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    bus.colr_fg = 4'd3;
    bus.colr_bg = 4'd5;
    bus.clear = 1'b1;
    bus.ch_valid = 1'b1;
    bus.ch_data = 21'h51;
    #1;
    chk("clr_rdy0", 32'(bus.ch_ready), 32'd0);
    step();
    bus.clear = 1'b0;
    bus.ch_valid = 1'b0;
    bus.colr_fg = 4'd0;
    bus.colr_bg = 4'd0;
    w0 = wr_cnt;
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) bcnt++;
      step();
    end
    chk("clr_busy_cycles", 32'(bcnt), 32'd12);
    chk("clr_writes", 32'(wr_cnt - w0), 32'd12);
    for (int i = 0; i < 12; i++) chk("clr_mem", mem[i], 32'h53000020);
    chk("clr_scroll", 32'(bus.scroll_offs), 32'd0);
    chk("clr_x", 32'(bus.cur_x), 32'd0);
    chk("clr_y", 32'(bus.cur_y), 32'd0);
    chk("clr_rdy1", 32'(bus.ch_ready), 32'd1);

    // Reset in the middle of a clear
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    step();
    step();
    chk("mid_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    step();
    chk("mid_we", 32'(bus.tram_we), 32'd0);
    chk("mid_busy_off", 32'(bus.busy), 32'd0);
    chk("mid_rdy_rst", 32'(bus.ch_ready), 32'd0);
    step();
    chk("mid_rdy_rst2", 32'(bus.ch_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rdy_idle", 32'(bus.ch_ready), 32'd1);
    step();
    chk("mid_we_idle", 32'(bus.tram_we), 32'd0);
    chk("mid_busy_idle", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
